fft_stage_sequencer: RTL and testbench

Parametrised control sequencer for the in-place radix-2 DIF FFT core. It issues butterfly pair indices and twiddle indices stage by stage, and drains the butterfly pipeline internally after each stage using a configured latency, with no external clear signal. It supports forward/inverse mode, backpressure on issue, abort, and ping-pong data-bank selection across frames. It sits between the frame I/O controller and the butterfly datapath / address generator.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_drain_timer.sv | 33 +++
 rtl/fft_stage_sequencer.sv | 136 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 DIF FFT control blocks.
package fft_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Default-configuration widths (N = 32).
  localparam int unsigned FFT_N_DEF   = 32;
  localparam int unsigned FFT_LOG2N   = $clog2(FFT_N_DEF);
  localparam int unsigned FFT_PAIR_W  = $clog2(FFT_N_DEF / 2);
  localparam int unsigned FFT_STAGE_W = ($clog2(FFT_LOG2N) > 1) ? $clog2(FFT_LOG2N) : 1;

  function automatic int unsigned pair_w_f(input int unsigned n);
    return $clog2(n / 2);
  endfunction

  function automatic int unsigned stage_w_f(input int unsigned n);
    int unsigned l2;
    l2 = $clog2($clog2(n));
    return (l2 > 1) ? l2 : 1;
  endfunction

  // (pair mod (N >> (stage+1))) << stage; the modulus is a power of two.
  function automatic int unsigned twiddle_f(input int unsigned pair,
                                            input int unsigned stg,
                                            input int unsigned log2n);
    int unsigned mask;
    mask = (32'd1 << (log2n - stg - 1)) - 32'd1;
    return (pair & mask) << stg;
  endfunction

endpackage

// File: rtl/fft_drain_timer.sv
// Loadable down-counter with zero flag; used to wait out a fixed pipeline latency.
module fft_drain_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage-by-stage butterfly/twiddle issue sequencer for the in-place radix-2 DIF FFT,
// with internal pipeline drain between stages and per-frame bank rotation.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N          = 32,
  parameter int PIPE_DEPTH = 4,
  parameter int NUM_BANKS  = 2,
  parameter int PAIR_W     = pair_w_f(N),
  parameter int STAGE_W    = stage_w_f(N),
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               start_ready,
  input  logic               inverse_in,
  input  logic               abort,
  input  logic               issue_stall,
  output logic               issue_valid,
  output logic [PAIR_W-1:0]  pair_id,
  output logic [PAIR_W-1:0]  twiddle_idx,
  output logic [STAGE_W-1:0] stage,
  output logic [BANK_W-1:0]  bank,
  output logic               inverse,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LOG2N   = $clog2(N);
  localparam int          DRAIN_W = $clog2(PIPE_DEPTH) + 1;

  localparam logic [PAIR_W-1:0]  PAIR_LAST  = PAIR_W'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [BANK_W-1:0]  BANK_LAST  = BANK_W'(NUM_BANKS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

  state_t               state_d, state_q;
  logic [PAIR_W-1:0]    pair_id_d, pair_id_q;
  logic [STAGE_W-1:0]   stage_d, stage_q;
  logic [BANK_W-1:0]    bank_d, bank_q;
  logic                 inverse_d, inverse_q;
  logic                 drain_clr, drain_load, drain_en, drain_zero;

  fft_drain_timer #(.W(DRAIN_W)) u_drain (
    .clk      (clk),
    .reset    (reset),
    .clr      (drain_clr),
    .load     (drain_load),
    .load_val (DRAIN_LOAD),
    .en       (drain_en),
    .zero     (drain_zero)
  );

  always_comb begin
    state_d    = state_q;
    pair_id_d  = pair_id_q;
    stage_d    = stage_q;
    bank_d     = bank_q;
    inverse_d  = inverse_q;
    drain_clr  = 1'b0;
    drain_load = 1'b0;
    drain_en   = 1'b0;
    if (abort) begin
      // Abort outranks everything, including a same-cycle start in IDLE.
      state_d   = ST_IDLE;
      pair_id_d = '0;
      stage_d   = '0;
      drain_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d   = ST_ISSUE;
          inverse_d = inverse_in;
          pair_id_d = '0;
          stage_d   = '0;
        end
        ST_ISSUE: if (!issue_stall) begin
          if (pair_id_q == PAIR_LAST) begin
            state_d    = ST_DRAIN;
            drain_load = 1'b1;
          end else begin
            pair_id_d = pair_id_q + PAIR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_zero) begin
            if (stage_q == STAGE_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d   = ST_ISSUE;
              stage_d   = stage_q + STAGE_W'(1);
              pair_id_d = '0;
            end
          end else begin
            drain_en = 1'b1;
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          pair_id_d = '0;
          stage_d   = '0;
          bank_d    = (bank_q == BANK_LAST) ? '0 : bank_q + BANK_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pair_id_q <= '0;
      stage_q   <= '0;
      bank_q    <= '0;
      inverse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_id_q <= pair_id_d;
      stage_q   <= stage_d;
      bank_q    <= bank_d;
      inverse_q <= inverse_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign issue_valid = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign pair_id     = pair_id_q;
  assign stage       = stage_q;
  assign bank        = bank_q;
  assign inverse     = inverse_q;
  assign twiddle_idx = issue_valid ? PAIR_W'(twiddle_f(32'(pair_id_q), 32'(stage_q), LOG2N)) : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=8, PIPE_DEPTH=2, NUM_BANKS=2.
module tb_fft_stage_sequencer;

  localparam int N  = 8;
  localparam int PD = 2;
  localparam int NB = 2;
  localparam int PW = 2;
  localparam int SW = 2;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          reset, start, inverse_in, abort, issue_stall;
  logic          start_ready, issue_valid, inverse, busy, done;
  logic [PW-1:0] pair_id, twiddle_idx;
  logic [SW-1:0] stage;
  logic [BW-1:0] bank;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int tw_exp [3][4] = '{'{0, 1, 2, 3}, '{0, 2, 0, 2}, '{0, 0, 0, 0}};

  fft_stage_sequencer #(.N(N), .PIPE_DEPTH(PD), .NUM_BANKS(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_ready (start_ready),
    .inverse_in  (inverse_in),
    .abort       (abort),
    .issue_stall (issue_stall),
    .issue_valid (issue_valid),
    .pair_id     (pair_id),
    .twiddle_idx (twiddle_idx),
    .stage       (stage),
    .bank        (bank),
    .inverse     (inverse),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic chk_reset_vals();
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_pair_id",     32'(pair_id), 0);
    chk("rst_stage",       32'(stage), 0);
    chk("rst_bank",        32'(bank), 0);
    chk("rst_inverse",     32'(inverse), 0);
    chk("rst_done",        32'(done), 0);
    chk("rst_busy",        32'(busy), 0);
    chk("rst_twiddle",     32'(twiddle_idx), 0);
    chk("rst_start_ready", 32'(start_ready), 1);
  endtask

  task automatic begin_frame(input logic inv, input logic hold);
    inverse_in = inv;
    start = 1'b1;
    chk("start_ready", 32'(start_ready), 1);
    step();
    edge_cnt = 0;
    start = hold;
    inverse_in = ~inv;
  endtask

  // Walks one frame from the sample after the start edge through the first IDLE cycle.
  task automatic run_frame(input int st_s, input int st_p, input int st_n, input logic drain_stall,
                           input int exp_done, input int exp_inv, input int exp_bank);
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < 4; p++) begin
        chk("pair_id",     32'(pair_id), p);
        chk("stage",       32'(stage), s);
        chk("issue_valid", 32'(issue_valid), 1);
        chk("twiddle",     32'(twiddle_idx), tw_exp[s][p]);
        chk("inverse",     32'(inverse), exp_inv);
        chk("bank",        32'(bank), exp_bank);
        chk("done_early",  32'(done), 0);
        if (s == st_s && p == st_p) begin
          for (int k = 0; k < st_n; k++) begin
            issue_stall = 1'b1;
            step();
            chk("hold_pair",    32'(pair_id), p);
            chk("hold_stage",   32'(stage), s);
            chk("hold_twiddle", 32'(twiddle_idx), tw_exp[s][p]);
            chk("hold_valid",   32'(issue_valid), 1);
          end
        end
        issue_stall = 1'b0;
        step();
      end
      for (int d = 0; d < PD; d++) begin
        chk("drain_valid",   32'(issue_valid), 0);
        chk("drain_twiddle", 32'(twiddle_idx), 0);
        chk("drain_busy",    32'(busy), 1);
        issue_stall = drain_stall;
        step();
      end
    end
    issue_stall = 1'b0;
    chk("done",      32'(done), 1);
    chk("done_edge", 32'(edge_cnt), exp_done);
    chk("done_bank", 32'(bank), exp_bank);
    chk("done_busy", 32'(busy), 1);
    step();
    chk("post_done",        32'(done), 0);
    chk("post_busy",        32'(busy), 0);
    chk("post_start_ready", 32'(start_ready), 1);
    chk("post_bank",        32'(bank), (exp_bank + 1) % NB);
    chk("post_pair",        32'(pair_id), 0);
    chk("post_stage",       32'(stage), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    issue_stall = 1'b0;
    inverse_in = 1'b0;
    #12;
    chk_reset_vals();
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk_reset_vals();

    // Plain frame: done after edge 18, bank 0 -> 1.
    begin_frame(1'b0, 1'b0);
    run_frame(-1, -1, 0, 1'b0, 18, 0, 0);

    // Three stall cycles at stage 1 pair 2, stall also raised during drains.
    begin_frame(1'b0, 1'b0);
    run_frame(1, 2, 3, 1'b1, 21, 0, 1);

    // Abort during drain of stage 1.
    begin_frame(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("pre_abort_stage", 32'(stage), 1);
    chk("pre_abort_valid", 32'(issue_valid), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",        32'(busy), 0);
    chk("abort_start_ready", 32'(start_ready), 1);
    chk("abort_done",        32'(done), 0);
    chk("abort_pair",        32'(pair_id), 0);
    chk("abort_stage",       32'(stage), 0);
    chk("abort_bank",        32'(bank), 0);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_vs_start_busy", 32'(busy), 0);
    step();
    chk("abort_no_done", 32'(done), 0);
    begin_frame(1'b0, 1'b0);
    run_frame(-1, -1, 0, 1'b0, 18, 0, 0);

    // Inverse latched at start; inverse_in toggles right after acceptance.
    begin_frame(1'b1, 1'b0);
    run_frame(-1, -1, 0, 1'b0, 18, 1, 1);
    chk("inverse_idle_hold", 32'(inverse), 1);

    // Back-to-back frames with start held high.
    begin_frame(1'b0, 1'b1);
    run_frame(-1, -1, 0, 1'b0, 18, 0, 0);
    begin_frame(1'b0, 1'b1);
    run_frame(-1, -1, 0, 1'b0, 18, 0, 1);
    begin_frame(1'b0, 1'b0);
    run_frame(-1, -1, 0, 1'b0, 18, 0, 0);

    // Asynchronous reset mid-issue of stage 2.
    begin_frame(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) step();
    chk("pre_rst_stage",   32'(stage), 2);
    chk("pre_rst_pair",    32'(pair_id), 1);
    chk("pre_rst_bank",    32'(bank), 1);
    chk("pre_rst_inverse", 32'(inverse), 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1 reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
